// File: rtl/shift_unit_seq.sv
// Sequential shifter: captures an operand, then applies one single-bit shift or rotate step per
// clock for shamt cycles. Handshakes with the control FSM through start/busy/done.
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   ent,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         op,
    input  logic               load,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;

    // One-bit step for each operation. The unused op codes hold the data unchanged.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [2:0] o);
        case (o)
            3'b000:  return {d[WIDTH-2:0], 1'b0};
            3'b001:  return {1'b0, d[WIDTH-1:1]};
            3'b010:  return {d[WIDTH-1], d[WIDTH-1:1]};
            3'b011:  return {d[0], d[WIDTH-1:1]};
            3'b100:  return {d[WIDTH-2:0], d[WIDTH-1]};
            default: return d;
        endcase
    endfunction

    // NOTE: every register here uses non-blocking assignments so that all updates within a clock
    // edge see the values from before that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data <= load ? ent : data;
                        op_q <= op;
                        if (shamt == '0) begin
                            state <= DONE;
                        end else begin
                            cnt   <= shamt;
                            state <= SHIFT;
                        end
                    end else if (load) begin
                        data <= ent;
                    end
                end
                SHIFT: begin
                    data <= step(data, op_q);
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign result = data;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Randomised scoreboard bench for shift_unit_seq. The expected result and the done cycle are computed
// from whole-amount shift arithmetic, and a monitor process compares them when done is asserted.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ent;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic        load;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] result;

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .ent    (ent),
        .shamt  (shamt),
        .op     (op),
        .load   (load),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // The whole-amount shift or rotate that a run of n single-bit steps should produce.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [2:0] o, input int n);
        logic [63:0] dd;
        dd = {d, d};
        case (o)
            3'd0: return d << n;
            3'd1: return d >> n;
            3'd2: return 32'($signed(d) >>> n);
            3'd3: begin dd = dd >> n; return dd[31:0];  end
            3'd4: begin dd = dd << n; return dd[63:32]; end
            default: return d;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_load(input logic [31:0] e);
        @(posedge clk); #1;
        load = 1'b1; ent = e;
        model_data = e;
        @(posedge clk); #1;
        load = 1'b0; ent = $urandom;
    endtask

    // Drive start for one edge (E0), push the expectation, and return with E0 just past.
    task automatic issue_start(input logic ld, input logic [31:0] e, input logic [2:0] o,
                               input logic [4:0] n, output int c0);
        exp_t x;
        @(posedge clk); #1;
        load = ld; ent = e; op = o; shamt = n; start = 1'b1;
        c0 = cyc + 1;
        model_data = ref_shift(ld ? e : model_data, o, int'(n));
        x.res = model_data;
        x.cyc = c0 + int'(n);
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0;
        ent = $urandom; op = 3'($urandom); shamt = 5'($urandom);
    endtask

    task automatic wait_done(input int c0, input logic [4:0] n);
        bit seen;
        logic exp_busy;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            exp_busy = (n != 0) && (cyc >= c0) && (cyc < c0 + int'(n));
            check("busy", 32'(busy), 32'(exp_busy));
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic ld, input logic [31:0] e, input logic [2:0] o, input logic [4:0] n);
        int c0;
        issue_start(ld, e, o, n, c0);
        wait_done(c0, n);
    endtask

    initial begin
        int c0;
        reset = 1'b1; ent = '0; shamt = '0; op = '0; load = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        do_load(32'h0000_0001);
        run_op(1'b0, 32'h0, 3'd0, 5'd4);
        check("sll4_result", result, 32'h0000_0010);
        run_op(1'b1, 32'h8000_0000, 3'd2, 5'd31);
        check("sra31_result", result, 32'hFFFF_FFFF);
        run_op(1'b1, 32'h8000_0000, 3'd1, 5'd31);
        check("srl31_result", result, 32'h0000_0001);
        run_op(1'b1, 32'h0000_0001, 3'd3, 5'd1);
        check("ror1_result", result, 32'h8000_0000);
        run_op(1'b1, 32'h8000_0000, 3'd4, 5'd1);
        check("rol1_result", result, 32'h0000_0001);
        do_load(32'hDEAD_BEEF);
        run_op(1'b0, 32'h0, 3'd0, 5'd0);
        check("shamt0_result", result, 32'hDEAD_BEEF);
        run_op(1'b1, 32'hA5A5_0F0F, 3'd6, 5'd7);
        check("hold_op_result", result, 32'hA5A5_0F0F);

        // start+load during SHIFT must be ignored
        do_load(32'h0000_00FF);
        issue_start(1'b0, 32'h0, 3'd0, 5'd8, c0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; load = 1'b1; ent = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0;
        wait_done(c0, 5'd8);
        check("ignored_start_result", result, 32'h0000_FF00);

        // Reset mid-operation aborts without a done pulse
        issue_start(1'b0, 32'h0, 3'd0, 5'd20, c0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        model_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_result", result, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        do_load(32'h0000_0003);
        run_op(1'b0, 32'h0, 3'd0, 5'd1);
        check("post_abort_result", result, 32'h0000_0006);

        // Randomised operations, including hold op codes and held-data reuse
        for (int i = 0; i < 40; i++) begin
            logic [4:0] n;
            n = (i % 8 == 0) ? 5'd0 : (i % 8 == 1) ? 5'd31 : 5'($urandom);
            if ($urandom_range(0, 3) == 0) do_load($urandom);
            run_op(1'($urandom), $urandom, 3'($urandom_range(0, 7)), n);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
